// File: rtl/gf8_pkg.sv
// Shared GF(2^8) types and the polynomial-basis reduction used by the
// multiply/accumulate datapath.
package gf8_pkg;

    localparam logic [8:0] GF8_POLY_AES = 9'h11B;

    typedef logic [7:0]  gf8_t;
    typedef logic [14:0] gf8_prod_t;

    // Fold coefficients 14..8 back into the low byte, highest first, so that
    // each fold can only disturb bits below the one being cleared.
    function automatic gf8_t gf8_reduce(gf8_prod_t p, logic [8:0] poly);
        gf8_prod_t t;
        t = p;
        for (int i = 14; i >= 8; i--) begin
            if (t[i]) begin
                t = t ^ (gf8_prod_t'(poly) << (i - 8));
            end
        end
        return t[7:0];
    endfunction

endpackage

// File: rtl/gf8_reduce_comb.sv
// Combinational reduction of a 15-coefficient GF(2)[x] product modulo poly.
module gf8_reduce_comb
    import gf8_pkg::*;
(
    input  gf8_prod_t  p,
    input  logic [8:0] poly,
    output gf8_t       r
);

    assign r = gf8_reduce(p, poly);

endmodule

// File: rtl/gf8_mac_reduce.sv
// Reduces split partial products modulo POLY and XOR-accumulates each group
// into one GF(2^8) dot-product result.
module gf8_mac_reduce
    import gf8_pkg::*;
#(
    parameter logic [8:0] POLY  = GF8_POLY_AES,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_lo,
    input  logic [7:0]       in_hi,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // Handshake: a beat moves when valid && ready on a rising edge; a producer
    // holding valid keeps its payload stable until that edge, and ready never
    // depends combinationally on the same interface's valid.

    gf8_prod_t        prod;
    gf8_t             prod_red;
    logic             r1_valid;
    logic             r1_last;
    gf8_t             r1_data;
    gf8_t             acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             s2_take;
    logic             in_fire;
    logic             out_fire;
    gf8_t             acc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;

    assign prod = {in_hi, in_lo};

    gf8_reduce_comb u_reduce (
        .p    (prod),
        .poly (POLY),
        .r    (prod_red)
    );

    // A last beat may only leave S1 when the output register is free or
    // draining this cycle; non-last beats never touch the output register.
    assign s2_take  = r1_valid && (!r1_last || !out_valid || out_ready);
    assign in_ready = !rst && (!r1_valid || s2_take);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign acc_n = acc ^ r1_data;
    assign cnt_n = cnt + CNT_W'(1);
    assign ovf_n = ovf | (&cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_last  <= 1'b0;
            r1_data  <= '0;
        end else if (in_fire) begin
            r1_valid <= 1'b1;
            r1_last  <= in_last;
            r1_data  <= prod_red;
        end else if (s2_take) begin
            r1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (s2_take) begin
                if (r1_last) begin
                    out_data  <= acc_n;
                    out_count <= cnt_n;
                    out_ovf   <= ovf_n;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc <= acc_n;
                    cnt <= cnt_n;
                    ovf <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf8_mac_reduce.sv
// Directed bench for gf8_mac_reduce: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus so counter wrap can be observed.
module tb_gf8_mac_reduce;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_lo;
    logic [7:0] in_hi;
    logic       in_last;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       out_ovf;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic [1:0] out_count2;
    logic       out_ovf2;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    gf8_mac_reduce #(.POLY(9'h11B), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    gf8_mac_reduce #(.POLY(9'h11B), .CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_last   (in_last),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2),
        .out_count (out_count2),
        .out_ovf   (out_ovf2)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: starts and ends at a negedge; waits (bounded) for in_ready.
    task automatic send_beat(input logic [7:0] hi, input logic [6:0] lo, input logic last);
        int t;
        in_valid = 1'b1;
        in_hi    = hi;
        in_lo    = lo;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a result on both instances, returns it and drains it.
    task automatic take_result(output logic [7:0] d, output logic [7:0] c, output logic o,
                               output logic [7:0] d2, output logic [1:0] c2, output logic o2);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
        end
        d  = out_data;
        c  = out_count;
        o  = out_ovf;
        d2 = out_data2;
        c2 = out_count2;
        o2 = out_ovf2;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_hi     = 8'h00;
        in_lo     = 7'h11;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 8'h00 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%h count=%0d ovf=%0b required 0/00/0/0",
                     out_valid, out_data, out_count, out_ovf);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b required 1", in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: out_valid=%0b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_aes_vector();
        logic [7:0] d, c, d2;
        logic [1:0] c2;
        logic o, o2;
        send_beat(8'h56, 7'h79, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL aes_latency_early: out_valid=%0b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL aes_latency: out_valid=%0b required 1", out_valid);
        end
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d !== 8'hC1 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL aes_result: data=%h count=%0d ovf=%0b required c1/1/0", d, c, o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d, c, d2;
        logic [1:0] c2;
        logic o, o2;
        send_beat(8'h02, 7'h00, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d !== 8'h1B || c !== 8'd1) begin
            errors++;
            $display("FAIL wrap_reduce: data=%h count=%0d required 1b/1", d, c);
        end
        send_beat(8'h00, 7'h55, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d !== 8'h55 || c !== 8'd1) begin
            errors++;
            $display("FAIL wrap_passthru: data=%h count=%0d required 55/1", d, c);
        end
    endtask

    task automatic test_dot_product();
        logic [7:0] d, c, d2;
        logic [1:0] c2;
        logic o, o2;
        send_beat(8'h56, 7'h79, 1'b0);
        send_beat(8'h02, 7'h00, 1'b0);
        send_beat(8'h00, 7'h01, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d !== 8'hDB || c !== 8'd3 || o !== 1'b0) begin
            errors++;
            $display("FAIL dot_product: data=%h count=%0d ovf=%0b required db/3/0", d, c, o);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        int held_bad;
        int t;
        out_ready = 1'b0;
        send_beat(8'h00, 7'h01, 1'b0);
        send_beat(8'h00, 7'h02, 1'b1);
        send_beat(8'h00, 7'h04, 1'b0);
        send_beat(8'h00, 7'h08, 1'b1);
        exp_q.push_back({8'h03, 8'd2});
        exp_q.push_back({8'h0C, 8'd2});
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %0b required 0", in_ready);
        end
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h03 || out_count !== 8'd2 || in_ready !== 1'b0)
                held_bad++;
            @(negedge clk);
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL bp_hold: unstable cycles=%0d required 0", held_bad);
        end
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 10) begin
            if (out_valid) begin
                exp = exp_q.pop_front();
                checks++;
                if ({out_data, out_count} !== exp) begin
                    errors++;
                    $display("FAIL bp_order: data=%h count=%0d required %h/%0d",
                             out_data, out_count, exp[15:8], exp[7:0]);
                end
            end
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] d, c, d2;
        logic [1:0] c2;
        logic o, o2;
        send_beat(8'h00, 7'h01, 1'b0);
        send_beat(8'h00, 7'h02, 1'b0);
        send_beat(8'h00, 7'h04, 1'b0);
        send_beat(8'h00, 7'h08, 1'b0);
        send_beat(8'h00, 7'h10, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d2 !== 8'h1F || c2 !== 2'd1 || o2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_narrow: data=%h count=%0d ovf=%0b required 1f/1/1", d2, c2, o2);
        end
        checks++;
        if (d !== 8'h1F || c !== 8'd5 || o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wide: data=%h count=%0d ovf=%0b required 1f/5/0", d, c, o);
        end
        send_beat(8'h00, 7'h03, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (c2 !== 2'd1 || o2 !== 1'b0 || d2 !== 8'h03) begin
            errors++;
            $display("FAIL ovf_clears: data=%h count=%0d ovf=%0b required 03/1/0", d2, c2, o2);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d, c, d2;
        logic [1:0] c2;
        logic o, o2;
        send_beat(8'h00, 7'h10, 1'b0);
        send_beat(8'h00, 7'h20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        send_beat(8'h00, 7'h55, 1'b1);
        take_result(d, c, o, d2, c2, o2);
        checks++;
        if (d !== 8'h55 || c !== 8'd1) begin
            errors++;
            $display("FAIL midrst_result: data=%h count=%0d required 55/1", d, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        logic [7:0] exp_b[4];
        int stalls;
        exp_b[0] = 8'hC1;
        exp_b[1] = 8'h1B;
        exp_b[2] = 8'h55;
        exp_b[3] = 8'h01;
        out_ready = 1'b1;
        stalls = 0;
        fork
            begin
                send_beat(8'h56, 7'h79, 1'b1);
                send_beat(8'h02, 7'h00, 1'b1);
                send_beat(8'h00, 7'h55, 1'b1);
                send_beat(8'h00, 7'h01, 1'b1);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (in_valid && !in_ready) stalls++;
                    if (out_valid && out_ready) got.push_back(out_data);
                end
            end
        join
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL b2b_bubbles: stalls=%0d required 0", stalls);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: results=%0d required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", i, got[i], exp_b[i]);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aes_vector();
        test_wrap();
        test_dot_product();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
